// File: rtl/dfe_isi_canceller.sv
// Decision-feedback ISI canceller ahead of the PAM4 slicer: subtracts post-cursor ISI built from past decisions.
// Optional macro DFE_ROUND_EN: round the ISI estimate half-up instead of flooring it.
module dfe_isi_canceller #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int TAP_WIDTH             = 8,
    parameter int TAP_FRAC              = 6,
    parameter int FB_TIMEOUT            = 15,
    localparam int N      = PULSE_RESPONSE_LENGTH,
    localparam int SR     = SIGNAL_RESOLUTION,
    localparam int ADDR_W = $clog2(PULSE_RESPONSE_LENGTH),
    localparam int EST_W  = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic signed [SR-1:0]     sample_in,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     tap_wr,
    input  logic [ADDR_W-1:0]        tap_addr,
    input  logic signed [TAP_WIDTH-1:0] tap_data,
    output logic signed [EST_W-1:0]  estimation,
    output logic                     e_valid,
    input  logic signed [SR-1:0]     fb_value,
    input  logic                     fb_valid,
    output logic                     fb_timeout,
    output logic [1:0]               dbg_state
);

    localparam int SUM_W  = TAP_WIDTH + SR + $clog2(N);
    localparam int DIFF_W = SUM_W + 1;
    localparam int PROD_W = TAP_WIDTH + SR;
    localparam int CNT_W  = $clog2(FB_TIMEOUT + 1);
    localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'((1 << (SR - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] SAT_MIN = -DIFF_W'(1 << (SR - 1));

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, EMIT = 2'd2, WAIT_FB = 2'd3} state_t;

    state_t state_q, state_d;

    logic signed [TAP_WIDTH-1:0] taps [1:N-1];
    logic signed [SR-1:0]        hist [1:N-1];
    logic signed [SR-1:0]        sample_r;
    logic [CNT_W-1:0]            wait_cnt;

    logic                 sample_ld, est_ld, hist_push, cnt_clr, cnt_inc, timeout_set;
    logic signed [SR-1:0] push_val;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  isi_sum, isi;
    logic signed [DIFF_W-1:0] diff;
    logic signed [SR-1:0]     sat;

    // Handshake: a sample transfers on a clk edge where s_valid && s_ready; e_valid is a
    // single-cycle pulse with no back-pressure; fb_value transfers on fb_valid only in WAIT_FB.
    assign s_ready   = rstn && (state_q == IDLE);
    assign e_valid   = rstn && (state_q == EMIT);
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        sample_ld   = 1'b0;
        est_ld      = 1'b0;
        hist_push   = 1'b0;
        push_val    = '0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    sample_ld = 1'b1;
                    state_d   = MAC;
                end
            end
            MAC: begin
                est_ld  = 1'b1;
                state_d = EMIT;
            end
            EMIT: state_d = WAIT_FB;
            WAIT_FB: begin
                if (fb_valid) begin
                    hist_push = 1'b1;
                    push_val  = fb_value;
                    cnt_clr   = 1'b1;
                    state_d   = IDLE;
                end else if (wait_cnt == CNT_W'(FB_TIMEOUT - 1)) begin
                    // Missed decision: treat it as zero so the history stays aligned to symbols.
                    hist_push   = 1'b1;
                    cnt_clr     = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        isi_sum = '0;
        prod    = '0;
        for (int k = 1; k < N; k++) begin
            prod    = taps[k] * hist[k];
            isi_sum = isi_sum + SUM_W'(prod);
        end
`ifdef DFE_ROUND_EN
        isi = (isi_sum + SUM_W'(1 << (TAP_FRAC - 1))) >>> TAP_FRAC;
`else
        isi = isi_sum >>> TAP_FRAC;
`endif
        diff = DIFF_W'(sample_r) - DIFF_W'(isi);
        if (diff > SAT_MAX)      sat = SAT_MAX[SR-1:0];
        else if (diff < SAT_MIN) sat = SAT_MIN[SR-1:0];
        else                     sat = diff[SR-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 1; k < N; k++) begin
                taps[k] <= '0;
                hist[k] <= '0;
            end
            sample_r   <= '0;
            wait_cnt   <= '0;
            estimation <= '0;
            fb_timeout <= 1'b0;
        end else begin
            // Tap 0 is the main cursor and never cancelled, so it has no storage.
            if (state_q == IDLE && tap_wr && tap_addr != '0 && 32'(tap_addr) < N)
                taps[tap_addr] <= tap_data;
            if (sample_ld) sample_r <= sample_in;
            if (est_ld)    estimation <= EST_W'(sat);
            if (hist_push) begin
                for (int k = N - 1; k >= 2; k--) hist[k] <= hist[k-1];
                hist[1] <= push_val;
            end
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
            if (timeout_set) fb_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/dfe_isi_canceller.md
Name: dfe_isi_canceller

Overview:
- Decision-feedback ISI canceller that sits directly upstream of the PAM4 slicer in the Rx_sim chain.
- Accepts one received channel sample per symbol and subtracts post-cursor ISI, computed from stored past decisions and programmable pulse-response taps.
- Presents the result as `estimation`/`e_valid` to the slicer.
- Captures the slicer's `feedback_value`/`f_valid` into its decision history, closing the DFE loop.

Parameters:
- PULSE_RESPONSE_LENGTH, 5: total taps. h[0] is the main cursor and is not cancelled; h[1..N-1] are post-cursors.
- SIGNAL_RESOLUTION, 8: width of signed sample and decision values.
- SYMBOL_SEPERATION, 56: PAM4 level spacing. Legal decisions are ±28 and ±84.
- TAP_WIDTH, 8: signed tap width.
- TAP_FRAC, 6: fractional bits in a tap (64 = 1.0).
- FB_TIMEOUT, 15: WAIT_FB cycles allowed before the block gives up on feedback.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- sample_in  in  SIGNAL_RESOLUTION  signed received sample
- s_valid  in  1  sample_in valid
- s_ready  out  1  block can accept a sample
- tap_wr  in  1  tap write strobe
- tap_addr  in  $clog2(PULSE_RESPONSE_LENGTH)  tap index
- tap_data  in  TAP_WIDTH  signed tap value
- estimation  out  SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH  signed ISI-cancelled sample, sign-extended
- e_valid  out  1  estimation valid (one-cycle pulse)
- fb_value  in  SIGNAL_RESOLUTION  signed slicer decision
- fb_valid  in  1  fb_value valid
- fb_timeout  out  1  sticky flag: feedback was missed

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE; taps and history hist[1..N-1] cleared to 0; wait counter cleared.
  - estimation=0, e_valid=0, fb_timeout=0, s_ready=0 while rstn=0.
  - Reset mid-operation aborts any symbol in flight; no e_valid is issued for it.
- FSM states: IDLE, MAC, EMIT, WAIT_FB.
  - IDLE: s_ready=1. On s_valid, register sample_in and go to MAC.
  - MAC: s_ready=0. Compute isi = Σ_{k=1}^{N-1} h[k]*hist[k]. Compute the full-precision sum with width TAP_WIDTH+SIGNAL_RESOLUTION+$clog2(N), then arithmetic-shift right by TAP_FRAC (floor).
    - diff = sample − isi.
    - Saturate diff to [−2^(SR−1), 2^(SR−1)−1].
    - Sign-extend to the estimation width and register it into `estimation` at the end of MAC.
    - Go to EMIT.
  - EMIT: e_valid=1 for exactly this cycle; go to WAIT_FB.
  - WAIT_FB: the slicer updates its registered output one cycle after e_valid, so fb_value is sampled from the first WAIT_FB cycle onward.
    - If fb_valid=1: shift hist (hist[k]←hist[k−1] for k≥2, hist[1]←fb_value), clear the counter, go to IDLE.
    - Otherwise increment the counter. When the counter reaches FB_TIMEOUT: push 0 into hist[1], set fb_timeout (sticky until reset), go to IDLE.
- Latency and throughput:
  - Handshake at edge 0; e_valid high in the 2nd cycle after acceptance.
  - Minimum 4 cycles per symbol.
- estimation holds its value between updates.
- Tap writes:
  - Honoured only in IDLE; ignored in all other states. Writes to tap_addr=0 and out-of-range tap_addr are ignored.
  - A tap write and a sample accept in the same IDLE cycle are both performed, and that sample uses the new tap value.
- fb_valid outside WAIT_FB is ignored; the slicer's f_valid is sticky, so only WAIT_FB sampling counts.
- Decisions outside {±28, ±84} are stored as-is, without checking.

Optional Feature:
- Macro: DFE_ROUND_EN.
- Defined: isi is rounded half-up, (sum + 2^(TAP_FRAC−1)) >>> TAP_FRAC, before the subtraction.
- Undefined: isi is plain arithmetic shift (floor).
- All other behaviour is identical either way.

Test Plan:
- Reset, all taps 0, sample 40 → estimation=40, e_valid pulses 2 cycles after accept; fb_value=28 → hist[1]=28.
- h[1]=32, hist[1]=28, sample 40 → isi=14, estimation=26; then fb=−84, sample −10 → isi=−42, estimation=32.
- h[1]=5, hist[1]=−28, sample 0 → estimation=3 without DFE_ROUND_EN, 2 with it.
- h[1]=127, hist[1]=−84, sample 120 → isi=−167, diff=287, estimation saturates to 127; with hist[1]=84 and sample −120 → estimation −128.
- Withhold fb_valid for 15 WAIT_FB cycles → fb_timeout=1, hist[1]=0, s_ready returns to 1; tap_wr issued during MAC is ignored (tap readback via next estimation unchanged).
- Assert rstn=0 in EMIT/WAIT_FB → e_valid=0 next cycle, history and taps 0, fb_timeout=0, next sample 40 → estimation=40.
